floating_point_adder: RTL and testbench

- Pipelined IEEE-754 single-precision adder: computes a+b for one operand pair per clock, no backpressure.
- Sits in the FPU datapath of the basic-arithmetic block; operands and result use the shared float_point_num packed struct.
- Status code res_state qualifies each output cycle.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_lzc.sv | 13 +
 rtl/floating_point_adder.sv | 163 ++++++++++++++++
 tb/tb_floating_point_adder.sv | 108 ++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float type, constants and status codes for the FPU datapath
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef enum logic [1:0] {
        RS_NONE     = 2'b00,
        RS_VALID    = 2'b01,
        RS_OVERFLOW = 2'b10,
        RS_INVALID  = 2'b11
    } res_state_e;

    typedef enum logic [1:0] {C_ZERO, C_NORM, C_INF, C_NAN} fclass_e;

    function automatic fclass_e classify(input float_point_num x);
        return x.exp == 8'h0 ? C_ZERO : x.exp != EXP_MAX ? C_NORM : x.mant == '0 ? C_INF : C_NAN;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: leading-zero count of a 27-bit word (27 when the word is zero)
module fpu_lzc (
    input  logic [26:0] x,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < 27; i++)
            if (x[i]) cnt = 5'(26 - i);
    end

endmodule

// File: rtl/floating_point_adder.sv
// floating_point_adder: pipelined single-precision adder, input register plus six logic stages
module floating_point_adder
    import fpu_pkg::*;
#(
    parameter int STAGES = 6,
    parameter int WIDTH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  float_point_num   a,
    input  float_point_num   b,
    input  logic             arg_vld,
    output float_point_num   result,
    output logic [WIDTH-1:0] res_state
);

    localparam int D = STAGES - 5;

    if (WIDTH != 2) begin : g_bad_width
        $error("floating_point_adder: WIDTH must be 2");
    end
    if (STAGES < 6) begin : g_bad_stages
        $error("floating_point_adder: STAGES must be at least 6");
    end

    logic [5:0]     vld;
    float_point_num s0_a, s0_b, s1_a, s1_b;
    logic           s1_sp, s2_sp, s3_sp, s4_sp, s5_sp;
    logic [31:0]    s1_spr, s2_spr, s3_spr, s4_spr, s5_spr;
    res_state_e     s1_sps, s2_sps, s3_sps, s4_sps, s5_sps;
    logic           s2_sign, s3_sign, s4_sign, s5_sign;
    logic           s2_sub, s3_sub;
    logic [7:0]     s2_exp, s3_exp, s4_exp, s5_exp, s2_diff;
    logic [23:0]    s2_sigl, s2_sigs;
    logic [26:0]    s3_sigl, s3_sigs, s5_m;
    logic [27:0]    s4_sum;

    always_ff @(posedge clk)
        vld <= rst ? 6'h0 : {vld[4:0], arg_vld};

    // stage 1: flush denormals, classify, resolve every non-normal case up front
    float_point_num fa, fb, l2, m2;
    fclass_e        ca, cb;
    logic           inv1, sp1;
    logic [31:0]    spr1;
    always_comb begin
        fa   = {s0_a.sign, s0_a.exp, s0_a.exp == 8'h0 ? 23'h0 : s0_a.mant};
        fb   = {s0_b.sign, s0_b.exp, s0_b.exp == 8'h0 ? 23'h0 : s0_b.mant};
        ca   = classify(fa);
        cb   = classify(fb);
        inv1 = ca == C_NAN || cb == C_NAN || (ca == C_INF && cb == C_INF && fa.sign != fb.sign);
        sp1  = ca != C_NORM || cb != C_NORM;
        spr1 = inv1 ? QNAN : ca == C_INF ? fa : cb == C_INF ? fb :
               (ca == C_ZERO && cb == C_ZERO) ? {fa.sign & fb.sign, 31'h0} :
               ca == C_ZERO ? fb : fa;
    end

    // stage 2: larger magnitude first
    logic a_big;
    always_comb begin
        a_big = {s1_a.exp, s1_a.mant} >= {s1_b.exp, s1_b.mant};
        l2    = a_big ? s1_a : s1_b;
        m2    = a_big ? s1_b : s1_a;
    end

    // stage 3: align into a 27-bit frame of hidden.mant[22:0], guard, round, sticky
    logic [49:0] wide;
    logic [26:0] al3;
    always_comb begin
        wide = {s2_sigs, 26'h0} >> s2_diff[4:0];
        al3  = s2_diff >= 8'd26 ? 27'd1 : {wide[49:24], |wide[23:0]};
    end

    // stage 5: normalize; zero sums and underflows leave through the special path
    logic [4:0]  lz;
    logic [26:0] n5;
    logic [9:0]  e5;
    logic        zero5, uf5;
    fpu_lzc u_lzc (.x(s4_sum[26:0]), .cnt(lz));
    always_comb begin
        n5    = s4_sum[27] ? {s4_sum[27:2], s4_sum[1] | s4_sum[0]} : s4_sum[26:0] << lz;
        e5    = s4_sum[27] ? {2'b0, s4_exp} + 10'd1 : {2'b0, s4_exp} - {5'b0, lz};
        zero5 = s4_sum == '0;
        uf5   = e5[9] || e5[8:0] == '0;
    end

    // stage 6: round to nearest even, renormalize on carry, saturate to inf
    logic        rnd, ovf;
    logic [24:0] m6;
    logic [8:0]  e6;
    logic [31:0] pk;
    res_state_e  st6;
    always_comb begin
        rnd = s5_m[2] & (s5_m[3] | s5_m[1] | s5_m[0]);
        m6  = {1'b0, s5_m[26:3]} + {24'h0, rnd};
        e6  = {1'b0, s5_exp} + {8'h0, m6[24]};
        ovf = e6 >= 9'd255;
        pk  = s5_sp ? s5_spr : ovf ? {s5_sign, EXP_MAX, 23'h0} :
              {s5_sign, e6[7:0], m6[24] ? m6[23:1] : m6[22:0]};
        st6 = s5_sp ? s5_sps : ovf ? RS_OVERFLOW : RS_VALID;
    end

    always_ff @(posedge clk) begin
        s0_a    <= a;
        s0_b    <= b;
        s1_a    <= fa;
        s1_b    <= fb;
        s1_sp   <= sp1;
        s1_spr  <= spr1;
        s1_sps  <= inv1 ? RS_INVALID : RS_VALID;
        s2_sp   <= s1_sp;
        s2_spr  <= s1_spr;
        s2_sps  <= s1_sps;
        s2_sign <= l2.sign;
        s2_sub  <= l2.sign ^ m2.sign;
        s2_exp  <= l2.exp;
        s2_diff <= l2.exp - m2.exp;
        s2_sigl <= {1'b1, l2.mant};
        s2_sigs <= {1'b1, m2.mant};
        s3_sp   <= s2_sp;
        s3_spr  <= s2_spr;
        s3_sps  <= s2_sps;
        s3_sign <= s2_sign;
        s3_sub  <= s2_sub;
        s3_exp  <= s2_exp;
        s3_sigl <= {s2_sigl, 3'b0};
        s3_sigs <= al3;
        s4_sp   <= s3_sp;
        s4_spr  <= s3_spr;
        s4_sps  <= s3_sps;
        s4_sign <= s3_sign;
        s4_exp  <= s3_exp;
        s4_sum  <= s3_sub ? {1'b0, s3_sigl} - {1'b0, s3_sigs} : {1'b0, s3_sigl} + {1'b0, s3_sigs};
        s5_sp   <= s4_sp | zero5 | uf5;
        s5_spr  <= s4_sp ? s4_spr : {~zero5 & s4_sign, 31'h0};
        s5_sps  <= s4_sp ? s4_sps : RS_VALID;
        s5_sign <= s4_sign;
        s5_exp  <= e5[7:0];
        s5_m    <= n5;
    end

    logic [31:0] dr [D];
    res_state_e  ds [D];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                dr[i] <= '0;
                ds[i] <= RS_NONE;
            end
        end else begin
            dr[0] <= vld[5] ? pk : dr[0];
            ds[0] <= vld[5] ? st6 : RS_NONE;
            for (int i = 1; i < D; i++) begin
                dr[i] <= dr[i-1];
                ds[i] <= ds[i-1];
            end
        end
    end

    assign result    = dr[D-1];
    assign res_state = ds[D-1];

endmodule

// File: tb/tb_floating_point_adder.sv
// tb_floating_point_adder: directed-vector bench with immediate assertions
module tb_floating_point_adder;
    import fpu_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           arg_vld = 1'b0;
    float_point_num a = '0, b = '0, result;
    logic [1:0]     res_state;
    int             total = 0, bad = 0;

    logic [31:0] sa [8] = '{32'h3F800000, 32'hBFC00000, 32'h40000000, 32'hC0800000,
                            32'h41200000, 32'h42C80000, 32'hBF400000, 32'h3F800000};
    logic [31:0] sb [8] = '{32'h40000000, 32'h3F000000, 32'hC0400000, 32'hC0800000,
                            32'hBE800000, 32'h3F000000, 32'h3E800000, 32'hBF7FFFFF};
    logic [31:0] sr [8] = '{32'h40400000, 32'hBF800000, 32'hBF800000, 32'hC1000000,
                            32'h411C0000, 32'h42C90000, 32'hBF000000, 32'h33800000};

    always #5 clk = ~clk;

    floating_point_adder #(.STAGES(6), .WIDTH(2)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .arg_vld(arg_vld),
        .result(result), .res_state(res_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic [1:0] s);
        @(negedge clk);
        a = x;
        b = y;
        arg_vld = 1'b1;
        @(negedge clk);
        arg_vld = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k < 6) check({tag, "_early"}, {30'h0, res_state}, 32'h0);
        end
        check({tag, "_res"}, result, r);
        check({tag, "_st"}, {30'h0, res_state}, {30'h0, s});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res", result, 32'h0);
        check("rst_st", {30'h0, res_state}, 32'h0);
        rst = 1'b0;
        op("add", 32'h3F933333, 32'h4094CCCD, 32'h40B9999A, 2'b01);
        op("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000, 2'b01);
        op("cancel_neg", 32'hBF800000, 32'h3F800000, 32'h00000000, 2'b01);
        op("tie_even", 32'h3F800000, 32'h33800000, 32'h3F800000, 2'b01);
        op("tie_odd", 32'h3F800001, 32'h33800000, 32'h3F800002, 2'b01);
        op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 2'b10);
        op("inf_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b11);
        op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b11);
        op("inf_fin", 32'hFF800000, 32'h3F800000, 32'hFF800000, 2'b01);
        op("denorm", 32'h00000001, 32'h3F800000, 32'h3F800000, 2'b01);
        op("neg0", 32'h80000000, 32'h80000000, 32'h80000000, 2'b01);
        op("mixed0", 32'h00000000, 32'h80000000, 32'h00000000, 2'b01);
        op("uflow", 32'h80C00000, 32'h00800000, 32'h80000000, 2'b01);
        op("gap", 32'h4B800000, 32'h3F800000, 32'h4B800000, 2'b01);
        @(negedge clk);
        check("hold_res", result, 32'h4B800000);
        check("hold_st", {30'h0, res_state}, 32'h0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c >= 7 && c < 15) begin
                check($sformatf("str%0d_res", c - 7), result, sr[c-7]);
                check($sformatf("str%0d_st", c - 7), {30'h0, res_state}, 32'h1);
            end else begin
                check($sformatf("str_idle%0d", c), {30'h0, res_state}, 32'h0);
            end
            arg_vld = c < 8;
            if (c < 8) begin
                a = sa[c];
                b = sb[c];
            end
        end
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40000000;
        arg_vld = 1'b1;
        @(negedge clk);
        arg_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_res", result, 32'h0);
        check("midrst_st", {30'h0, res_state}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("midrst_st%0d", k), {30'h0, res_state}, 32'h0);
            check($sformatf("midrst_res%0d", k), result, 32'h0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
